// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit saturating direction counters.
// Lookup is registered (request in T, response in T+1); one update per cycle.
// After reset or io_flush a sweep invalidates one set per cycle before lookups can hit.
// Optional build macro BTB_PERF_EN adds lookup/hit performance counters.
module btb_assoc #(
  parameter int unsigned SETS  = 64,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned TAG_W = 30 - $clog2(SETS)
) (
  input  logic        clock,
  input  logic        reset,
`ifdef BTB_PERF_EN
  output logic [31:0] io_perf_lookups,
  output logic [31:0] io_perf_hits,
`endif
  input  logic        io_flush,
  output logic        io_ready,
  input  logic        io_read_req_valid,
  input  logic [31:0] io_read_req_bits_pc,
  output logic        io_read_resp_valid,
  output logic        io_read_resp_hit,
  output logic [31:0] io_read_resp_target,
  output logic        io_read_resp_jump,
  input  logic        io_write_valid,
  input  logic [31:0] io_write_bits_pc,
  input  logic        io_write_bits_jump,
  input  logic [31:0] io_write_bits_target
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic StInit = 1'b0;
  localparam logic StRun  = 1'b1;

  logic             state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             run;

  // Entry storage; contents other than valid are don't-care until written.
  logic [WAYS-1:0]  valid_q  [SETS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [31:0]      target_q [SETS][WAYS];
  logic [1:0]       ctr_q    [SETS][WAYS];

  assign run      = (state_q == StRun);
  assign io_ready = run;

  // Sweep FSM: flush always restarts the sweep from set 0.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (io_flush) begin
      state_d = StInit;
      sweep_d = '0;
    end else if (state_q == StInit) begin
      if (sweep_q == IDX_W'(SETS - 1)) begin
        state_d = StRun;
      end
      sweep_d = sweep_q + 1'b1;
    end
  end

  // FSM state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInit;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [31:0]      rd_target;
  logic             rd_jump;

  assign rd_idx = io_read_req_bits_pc[IDX_W+1:2];
  assign rd_tag = io_read_req_bits_pc[IDX_W+2 +: TAG_W];

  // Tag compare; scanning downwards lets the lowest matching way win.
  always_comb begin
    rd_hit    = 1'b0;
    rd_target = '0;
    rd_jump   = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
        rd_hit    = 1'b1;
        rd_target = target_q[rd_idx][w];
        rd_jump   = ctr_q[rd_idx][w][1];
      end
    end
  end

  logic        resp_valid_q;
  logic        resp_hit_q;
  logic [31:0] resp_target_q;
  logic        resp_jump_q;
  logic        rd_hit_gated;

  assign rd_hit_gated = io_read_req_valid && run && rd_hit;

  // Response registers; a miss reports zero target and not-taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_target_q <= '0;
      resp_jump_q   <= 1'b0;
    end else begin
      resp_valid_q  <= io_read_req_valid;
      resp_hit_q    <= rd_hit_gated;
      resp_target_q <= rd_hit_gated ? rd_target : 32'h0;
      resp_jump_q   <= rd_hit_gated && rd_jump;
    end
  end

  assign io_read_resp_valid  = resp_valid_q;
  assign io_read_resp_hit    = resp_hit_q;
  assign io_read_resp_target = resp_target_q;
  assign io_read_resp_jump   = resp_jump_q;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_en;
  logic             wr_hit;
  logic [WAY_W-1:0] wr_hit_way;
  logic             wr_any_inv;
  logic [WAY_W-1:0] wr_inv_way;
  logic [WAY_W-1:0] wr_alloc_way;
  logic [WAY_W-1:0] victim_rd;
  logic             wr_alloc;
  logic             wr_evict;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;

  assign wr_idx = io_write_bits_pc[IDX_W+1:2];
  assign wr_tag = io_write_bits_pc[IDX_W+2 +: TAG_W];
  assign wr_en  = io_write_valid && run;

  // Find the lowest matching way and the lowest invalid way of the written set.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_way = '0;
    wr_any_inv = 1'b0;
    wr_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
        wr_hit     = 1'b1;
        wr_hit_way = WAY_W'(w);
      end
      if (!valid_q[wr_idx][w]) begin
        wr_any_inv = 1'b1;
        wr_inv_way = WAY_W'(w);
      end
    end
  end

  assign wr_alloc_way = wr_any_inv ? wr_inv_way : victim_rd;
  assign wr_alloc     = wr_en && !wr_hit && io_write_bits_jump;
  assign wr_evict     = wr_alloc && !wr_any_inv;
  assign ctr_cur      = ctr_q[wr_idx][wr_hit_way];

  // Saturating direction counter update for a hitting write.
  always_comb begin
    ctr_next = ctr_cur;
    if (io_write_bits_jump) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  // Entry update: sweep clears valid bits in INIT; hits train, taken misses allocate.
  always_ff @(posedge clock) begin
    if (state_q == StInit) begin
      valid_q[sweep_q] <= '0;
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx][wr_hit_way] <= ctr_next;
        if (io_write_bits_jump) begin
          target_q[wr_idx][wr_hit_way] <= io_write_bits_target;
        end
      end else if (io_write_bits_jump) begin
        valid_q[wr_idx][wr_alloc_way]  <= 1'b1;
        tag_q[wr_idx][wr_alloc_way]    <= wr_tag;
        target_q[wr_idx][wr_alloc_way] <= io_write_bits_target;
        ctr_q[wr_idx][wr_alloc_way]    <= 2'b10;
      end
    end
  end

  // Round-robin victim pointer per set; only exists with more than one way.
  if (WAYS > 1) begin : g_victim
    logic [WAY_W-1:0] victim_q [SETS];

    assign victim_rd = victim_q[wr_idx];

    // Pointer advances only when a valid entry was evicted.
    always_ff @(posedge clock) begin
      if (state_q == StInit) begin
        victim_q[sweep_q] <= '0;
      end else if (wr_evict) begin
        victim_q[wr_idx] <= victim_q[wr_idx] + 1'b1;
      end
    end
  end else begin : g_no_victim
    assign victim_rd = '0;
  end

`ifdef BTB_PERF_EN
  logic [31:0] perf_lookups_q;
  logic [31:0] perf_hits_q;

  // Performance counters; cleared by reset only, wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_lookups_q <= '0;
      perf_hits_q    <= '0;
    end else begin
      if (resp_valid_q) perf_lookups_q <= perf_lookups_q + 32'd1;
      if (resp_valid_q && resp_hit_q) perf_hits_q <= perf_hits_q + 32'd1;
    end
  end

  assign io_perf_lookups = perf_lookups_q;
  assign io_perf_hits    = perf_hits_q;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (SETS=64, WAYS=2): directed vector table plus
// hand-written sequences for the reset/flush sweep and same-cycle read/write.
module tb_btb_assoc;

  logic        clock;
  logic        reset;
  logic        io_flush;
  logic        io_ready;
  logic        io_read_req_valid;
  logic [31:0] io_read_req_bits_pc;
  logic        io_read_resp_valid;
  logic        io_read_resp_hit;
  logic [31:0] io_read_resp_target;
  logic        io_read_resp_jump;
  logic        io_write_valid;
  logic [31:0] io_write_bits_pc;
  logic        io_write_bits_jump;
  logic [31:0] io_write_bits_target;
`ifdef BTB_PERF_EN
  logic [31:0] io_perf_lookups;
  logic [31:0] io_perf_hits;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  btb_assoc #(
    .SETS (64),
    .WAYS (2)
  ) dut (
    .clock                (clock),
    .reset                (reset),
`ifdef BTB_PERF_EN
    .io_perf_lookups      (io_perf_lookups),
    .io_perf_hits         (io_perf_hits),
`endif
    .io_flush             (io_flush),
    .io_ready             (io_ready),
    .io_read_req_valid    (io_read_req_valid),
    .io_read_req_bits_pc  (io_read_req_bits_pc),
    .io_read_resp_valid   (io_read_resp_valid),
    .io_read_resp_hit     (io_read_resp_hit),
    .io_read_resp_target  (io_read_resp_target),
    .io_read_resp_jump    (io_read_resp_jump),
    .io_write_valid       (io_write_valid),
    .io_write_bits_pc     (io_write_bits_pc),
    .io_write_bits_jump   (io_write_bits_jump),
    .io_write_bits_target (io_write_bits_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_read;
    logic [31:0] pc;
    logic        jump;
    logic [31:0] target;
    logic        exp_hit;
    logic        exp_jump;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t wr(input logic [31:0] pc, input logic j, input logic [31:0] t);
    vec_t v;
    v.is_read = 1'b0; v.pc = pc; v.jump = j; v.target = t;
    v.exp_hit = 1'b0; v.exp_jump = 1'b0; v.exp_target = 32'h0;
    return v;
  endfunction

  function automatic vec_t rd(input logic [31:0] pc, input logic h, input logic j,
                              input logic [31:0] t);
    vec_t v;
    v.is_read = 1'b1; v.pc = pc; v.jump = 1'b0; v.target = 32'h0;
    v.exp_hit = h; v.exp_jump = j; v.exp_target = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_resp(input string name, input logic h, input logic j,
                            input logic [31:0] t);
    check({name, ".valid"},  {31'h0, io_read_resp_valid}, 32'h1);
    check({name, ".hit"},    {31'h0, io_read_resp_hit},   {31'h0, h});
    check({name, ".jump"},   {31'h0, io_read_resp_jump},  {31'h0, j});
    check({name, ".target"}, io_read_resp_target,         t);
  endtask

  task automatic do_read(input string name, input logic [31:0] pc, input logic h,
                         input logic j, input logic [31:0] t);
    io_read_req_valid   = 1'b1;
    io_read_req_bits_pc = pc;
    step();
    io_read_req_valid   = 1'b0;
    check_resp(name, h, j, t);
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    io_flush             = 1'b0;
    io_read_req_valid    = 1'b0;
    io_read_req_bits_pc  = 32'h0;
    io_write_valid       = 1'b0;
    io_write_bits_pc     = 32'h0;
    io_write_bits_jump   = 1'b0;
    io_write_bits_target = 32'h0;
    reset                = 1'b1;
    step();
    step();
    check("reset.resp_valid", {31'h0, io_read_resp_valid}, 32'h0);
    check("reset.hit",        {31'h0, io_read_resp_hit},   32'h0);
    check("reset.target",     io_read_resp_target,         32'h0);
    check("reset.jump",       {31'h0, io_read_resp_jump},  32'h0);
    reset = 1'b0;

    // Sweep after reset: ready low for 64 cycles; a read during INIT misses.
    for (int i = 0; i < 64; i++) begin
      check("init.ready", {31'h0, io_ready}, 32'h0);
      if (i == 6) begin
        io_read_req_valid = 1'b0;
        check_resp("init_read", 1'b0, 1'b0, 32'h0);
      end
      if (i == 5) begin
        io_read_req_valid   = 1'b1;
        io_read_req_bits_pc = 32'h0000_0100;
      end
      step();
    end
    check("run.ready", {31'h0, io_ready}, 32'h1);

    // Directed vector table (set 0 unless noted).
    vecs.push_back(wr(32'h1000, 1'b1, 32'h2000));            // alloc way0, ctr=2
    vecs.push_back(rd(32'h1000, 1'b1, 1'b1, 32'h2000));
    vecs.push_back(wr(32'h1000, 1'b0, 32'h0));               // ctr=1
    vecs.push_back(wr(32'h1000, 1'b0, 32'h0));               // ctr=0
    vecs.push_back(rd(32'h1000, 1'b1, 1'b0, 32'h2000));
    vecs.push_back(wr(32'h1000, 1'b0, 32'h0));               // stays 0
    vecs.push_back(rd(32'h1000, 1'b1, 1'b0, 32'h2000));
    vecs.push_back(wr(32'h1000, 1'b1, 32'h2000));            // ctr=1
    vecs.push_back(rd(32'h1000, 1'b1, 1'b0, 32'h2000));
    vecs.push_back(wr(32'h1000, 1'b1, 32'h2000));            // ctr=2
    vecs.push_back(wr(32'h1000, 1'b1, 32'h2000));            // ctr=3
    vecs.push_back(wr(32'h1000, 1'b1, 32'h2000));            // saturated 3
    vecs.push_back(rd(32'h1000, 1'b1, 1'b1, 32'h2000));
    vecs.push_back(wr(32'h1000, 1'b0, 32'h0));               // ctr=2
    vecs.push_back(rd(32'h1000, 1'b1, 1'b1, 32'h2000));
    vecs.push_back(wr(32'h2000, 1'b1, 32'h2222));            // invalid way1, ptr stays 0
    vecs.push_back(wr(32'h3000, 1'b1, 32'h3333));            // evict way0 (0x1000), ptr=1
    vecs.push_back(rd(32'h1000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(rd(32'h2000, 1'b1, 1'b1, 32'h2222));
    vecs.push_back(rd(32'h3000, 1'b1, 1'b1, 32'h3333));
    vecs.push_back(wr(32'h4000, 1'b1, 32'h4444));            // evict way1 (0x2000), ptr=0
    vecs.push_back(rd(32'h2000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(rd(32'h4000, 1'b1, 1'b1, 32'h4444));
    vecs.push_back(rd(32'h3000, 1'b1, 1'b1, 32'h3333));
    vecs.push_back(wr(32'h5000, 1'b0, 32'h5555));            // not-taken miss: no alloc
    vecs.push_back(rd(32'h5000, 1'b0, 1'b0, 32'h0));
    vecs.push_back(rd(32'h3000, 1'b1, 1'b1, 32'h3333));
    vecs.push_back(rd(32'h4000, 1'b1, 1'b1, 32'h4444));
    vecs.push_back(wr(32'h3000, 1'b1, 32'h3abc));            // taken hit updates target
    vecs.push_back(rd(32'h3000, 1'b1, 1'b1, 32'h3abc));
    vecs.push_back(wr(32'h1004, 1'b1, 32'h1234));            // set 1
    vecs.push_back(rd(32'h1004, 1'b1, 1'b1, 32'h1234));
    vecs.push_back(rd(32'h1104, 1'b0, 1'b0, 32'h0));         // set 1, other tag

    foreach (vecs[i]) begin
      if (vecs[i].is_read) begin
        do_read($sformatf("vec%0d", i), vecs[i].pc, vecs[i].exp_hit, vecs[i].exp_jump,
                vecs[i].exp_target);
      end else begin
        io_write_valid       = 1'b1;
        io_write_bits_pc     = vecs[i].pc;
        io_write_bits_jump   = vecs[i].jump;
        io_write_bits_target = vecs[i].target;
        step();
        io_write_valid       = 1'b0;
      end
    end

    // Same-cycle read and write to set 2: read sees pre-write contents.
    io_read_req_valid    = 1'b1;
    io_read_req_bits_pc  = 32'h1008;
    io_write_valid       = 1'b1;
    io_write_bits_pc     = 32'h1008;
    io_write_bits_jump   = 1'b1;
    io_write_bits_target = 32'h5a5a;
    step();
    io_read_req_valid = 1'b0;
    io_write_valid    = 1'b0;
    check_resp("rw_same", 1'b0, 1'b0, 32'h0);
    do_read("rw_after", 32'h1008, 1'b1, 1'b1, 32'h5a5a);

    // Flush: ready low for 64 cycles; reads miss and writes are dropped meanwhile.
    io_flush = 1'b1;
    step();
    io_flush = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check("flush.ready", {31'h0, io_ready}, 32'h0);
      if (i == 4) begin
        io_read_req_valid = 1'b0;
        io_write_valid    = 1'b0;
        check_resp("flush_read", 1'b0, 1'b0, 32'h0);
      end
      if (i == 3) begin
        io_read_req_valid    = 1'b1;
        io_read_req_bits_pc  = 32'h3000;
        io_write_valid       = 1'b1;
        io_write_bits_pc     = 32'h6000;
        io_write_bits_jump   = 1'b1;
        io_write_bits_target = 32'h6666;
      end
      step();
    end
    check("flush.ready_back", {31'h0, io_ready}, 32'h1);
    do_read("post_flush_3000", 32'h3000, 1'b0, 1'b0, 32'h0);
    do_read("post_flush_4000", 32'h4000, 1'b0, 1'b0, 32'h0);
    do_read("post_flush_1008", 32'h1008, 1'b0, 1'b0, 32'h0);
    do_read("dropped_6000",    32'h6000, 1'b0, 1'b0, 32'h0);

    // Normal operation resumes after the flush sweep.
    io_write_valid       = 1'b1;
    io_write_bits_pc     = 32'h3000;
    io_write_bits_jump   = 1'b1;
    io_write_bits_target = 32'h0077;
    step();
    io_write_valid = 1'b0;
    do_read("post_flush_alloc", 32'h3000, 1'b1, 1'b1, 32'h0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
